atm_session_ctrl: RTL
=====================

// Module: atm_session_ctrl
// PURPOSE
//  Transaction sequencer for one ATM front-end: card-in, PIN check with retry limit,
//  amount check against balance, cash-dispenser req/ack handshake, card eject/retain.
//  Sits between user-input decode and the shared cash dispenser; drives state/count for display.
// PARAMETERS
//  PIN_W        16    width of entered and stored PIN
//  AMT_W        16    width of amount and balance (unsigned)
//  MAX_TRIES    3     wrong-PIN attempts before card is retained (1..7)
//  TIMEOUT_CYC  1000  idle cycles allowed in PIN/AMOUNT before forced eject (>=2)
// PORTS
//  clk          in   1      single clock, all logic on posedge
//  reset        in   1      synchronous, active-low
//  card_insert  in   1      level, 1 = card present
//  pin_valid    in   1      1-cycle strobe, pin_in valid
//  pin_in       in   PIN_W  entered PIN
//  stored_pin   in   PIN_W  PIN read from card, stable while card present
//  amt_valid    in   1      1-cycle strobe, amt_in valid
//  amt_in       in   AMT_W  requested amount
//  balance      in   AMT_W  account balance, stable during session
//  disp_ack     in   1      dispenser done, 1-cycle strobe
//  disp_req     out  1      dispense request, held until ack
//  disp_amt     out  AMT_W  latched amount, stable while disp_req=1
//  card_eject   out  1      1-cycle pulse on entering EJECT
//  card_retain  out  1      1-cycle pulse on entering LOCK
//  out          out  1      1-cycle pulse: transaction completed (dispense acked)
//  err          out  3      0 none,1 bad PIN,2 locked,3 bad amount,4 timeout,5 aborted
//  state        out  3      IDLE=0 PIN=1 AMOUNT=2 DISPENSE=3 EJECT=4 LOCK=5
//  count        out  3      wrong-PIN attempts this session
// BEHAVIOUR
//  - reset==0 at posedge: state=IDLE, count=0, err=0, timer=0, all strobes/disp_req=0,
//    disp_amt=0, card_insert edge-detect history=1 (a card held through reset is not a new insert).
//  - All outputs registered; state advances the cycle after the qualifying input is sampled.
//  - IDLE: rising edge of card_insert (prev 0, now 1) -> PIN; clear count, err, timer.
//  - PIN priority: card_insert=0 -> IDLE, err=5; else pin_valid: match -> AMOUNT, err=0;
//    mismatch -> count+1, err=1; if count+1==MAX_TRIES -> LOCK, err=2; else timeout -> EJECT, err=4.
//  - AMOUNT priority: card_insert=0 -> IDLE, err=5; else amt_valid: amt_in==0 or amt_in>balance
//    -> EJECT, err=3; else disp_amt<=amt_in, disp_req<=1 -> DISPENSE; else timeout -> EJECT, err=4.
//    amt_in==balance is accepted. Compare is unsigned, full AMT_W.
//  - Timer: counts cycles in PIN/AMOUNT; cleared on state entry and on any pin_valid/amt_valid;
//    timeout fires when timer==TIMEOUT_CYC-1 and no strobe that cycle.
//  - DISPENSE: disp_req held high; card removal and timeout ignored. disp_ack -> disp_req=0,
//    out=1 for one cycle, -> EJECT. disp_ack outside DISPENSE is ignored.
//  - EJECT: card_eject=1 on entry cycle only; stay until card_insert=0 -> IDLE (err held).
//  - LOCK: card_retain=1 on entry cycle only; next cycle -> IDLE. Still-high card_insert
//    does not restart a session (needs a fresh rising edge).
//  - err and count hold their value until the next session start in IDLE.
//  - Reset mid-DISPENSE drops disp_req the same edge; no out pulse.
// TESTING
//  T1 insert, pin=0x1234 (stored 0x1234), amt=500, bal=800, ack 4 cyc later -> states
//     0,1,2,3,4; disp_req 4 cyc, disp_amt=500, out 1 cyc, card_eject 1 cyc, err=0.
//  T2 three wrong PINs (MAX_TRIES=3) -> count 1,2 then LOCK, card_retain pulse, err=2, IDLE;
//     card_insert kept high -> stays IDLE.
//  T3 amt=801, bal=800 -> EJECT err=3, no disp_req; amt=800 -> accepted; amt=0 -> err=3.
//  T4 TIMEOUT_CYC=8, no input in PIN -> EJECT exactly 8 cyc after PIN entry, err=4;
//     pin_valid(wrong) at cycle 5 restarts count-down.
//  T5 card removed in AMOUNT -> IDLE, err=5; card removed in DISPENSE -> no effect, completes.
//  T6 reset=0 while disp_req=1 -> next edge state=0, disp_req=0, count=0, out never pulses.

Source files
------------

// File: rtl/atm_session_ctrl.sv
// ATM session sequencer: card-in, PIN check with retry limit, amount check,
// dispenser req/ack handshake and card eject/retain. All outputs registered.
module atm_session_ctrl #(
    parameter int PIN_W       = 16,
    parameter int AMT_W       = 16,
    parameter int MAX_TRIES   = 3,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_card_insert,
    input  logic             i_pin_valid,
    input  logic [PIN_W-1:0] i_pin_in,
    input  logic [PIN_W-1:0] i_stored_pin,
    input  logic             i_amt_valid,
    input  logic [AMT_W-1:0] i_amt_in,
    input  logic [AMT_W-1:0] i_balance,
    input  logic             i_disp_ack,
    output logic             o_disp_req,
    output logic [AMT_W-1:0] o_disp_amt,
    output logic             o_card_eject,
    output logic             o_card_retain,
    output logic             o_out,
    output logic [2:0]       o_err,
    output logic [2:0]       o_state,
    output logic [2:0]       o_count
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PIN      = 3'd1,
        S_AMOUNT   = 3'd2,
        S_DISPENSE = 3'd3,
        S_EJECT    = 3'd4,
        S_LOCK     = 3'd5
    } state_t;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_PIN     = 3'd1;
    localparam logic [2:0] ERR_LOCKED  = 3'd2;
    localparam logic [2:0] ERR_AMT     = 3'd3;
    localparam logic [2:0] ERR_TIMEOUT = 3'd4;
    localparam logic [2:0] ERR_ABORT   = 3'd5;

    localparam int               TIMER_W     = $clog2(TIMEOUT_CYC);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYC - 1);
    localparam logic [2:0]       TRIES_LIMIT = 3'(MAX_TRIES);

    state_t             r_state;
    logic [2:0]         r_count;
    logic [2:0]         r_err;
    logic [TIMER_W-1:0] r_timer;
    logic               r_disp_req;
    logic [AMT_W-1:0]   r_disp_amt;
    logic               r_card_eject;
    logic               r_card_retain;
    logic               r_out;
    logic               r_card_prev;

    state_t             w_state_next;
    logic [2:0]         w_count_next;
    logic [2:0]         w_err_next;
    logic [TIMER_W-1:0] w_timer_next;
    logic               w_disp_req_next;
    logic [AMT_W-1:0]   w_disp_amt_next;
    logic               w_card_eject_next;
    logic               w_card_retain_next;
    logic               w_out_next;

    logic               w_card_rise;
    logic               w_pin_match;
    logic               w_amt_bad;
    logic               w_timer_expired;
    logic [2:0]         w_count_inc;

    assign w_card_rise     = i_card_insert & ~r_card_prev;
    assign w_pin_match     = (i_pin_in == i_stored_pin);
    assign w_amt_bad       = (i_amt_in == '0) || (i_amt_in > i_balance);
    assign w_timer_expired = (r_timer == TIMER_LAST);
    assign w_count_inc     = r_count + 3'd1;

    always_comb begin
        w_state_next       = r_state;
        w_count_next       = r_count;
        w_err_next         = r_err;
        w_timer_next       = r_timer;
        w_disp_req_next    = r_disp_req;
        w_disp_amt_next    = r_disp_amt;
        w_card_eject_next  = 1'b0;
        w_card_retain_next = 1'b0;
        w_out_next         = 1'b0;

        case (r_state)
            S_IDLE: begin
                // Only a fresh insertion edge starts a session.
                if (w_card_rise) begin
                    w_state_next = S_PIN;
                    w_count_next = 3'd0;
                    w_err_next   = ERR_NONE;
                    w_timer_next = '0;
                end
            end

            S_PIN: begin
                if (!i_card_insert) begin
                    w_state_next = S_IDLE;
                    w_err_next   = ERR_ABORT;
                end else if (i_pin_valid) begin
                    w_timer_next = '0;
                    if (w_pin_match) begin
                        w_state_next = S_AMOUNT;
                        w_err_next   = ERR_NONE;
                    end else begin
                        w_count_next = w_count_inc;
                        w_err_next   = ERR_PIN;
                        if (w_count_inc == TRIES_LIMIT) begin
                            w_state_next       = S_LOCK;
                            w_err_next         = ERR_LOCKED;
                            w_card_retain_next = 1'b1;
                        end
                    end
                end else if (w_timer_expired) begin
                    w_state_next      = S_EJECT;
                    w_err_next        = ERR_TIMEOUT;
                    w_card_eject_next = 1'b1;
                    w_timer_next      = '0;
                end else begin
                    w_timer_next = r_timer + TIMER_W'(1);
                end
            end

            S_AMOUNT: begin
                if (!i_card_insert) begin
                    w_state_next = S_IDLE;
                    w_err_next   = ERR_ABORT;
                end else if (i_amt_valid) begin
                    w_timer_next = '0;
                    if (w_amt_bad) begin
                        w_state_next      = S_EJECT;
                        w_err_next        = ERR_AMT;
                        w_card_eject_next = 1'b1;
                    end else begin
                        w_state_next    = S_DISPENSE;
                        w_disp_amt_next = i_amt_in;
                        w_disp_req_next = 1'b1;
                    end
                end else if (w_timer_expired) begin
                    w_state_next      = S_EJECT;
                    w_err_next        = ERR_TIMEOUT;
                    w_card_eject_next = 1'b1;
                    w_timer_next      = '0;
                end else begin
                    w_timer_next = r_timer + TIMER_W'(1);
                end
            end

            S_DISPENSE: begin
                // Cash is committed: card removal and idle time cannot abort here.
                if (i_disp_ack) begin
                    w_disp_req_next   = 1'b0;
                    w_out_next        = 1'b1;
                    w_state_next      = S_EJECT;
                    w_card_eject_next = 1'b1;
                end
            end

            S_EJECT: begin
                if (!i_card_insert) begin
                    w_state_next = S_IDLE;
                end
            end

            S_LOCK: begin
                w_state_next = S_IDLE;
            end

            default: begin
                w_state_next    = S_IDLE;
                w_disp_req_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state       <= S_IDLE;
            r_count       <= 3'd0;
            r_err         <= ERR_NONE;
            r_timer       <= '0;
            r_disp_req    <= 1'b0;
            r_disp_amt    <= '0;
            r_card_eject  <= 1'b0;
            r_card_retain <= 1'b0;
            r_out         <= 1'b0;
            // A card held through reset must not look like a new insertion.
            r_card_prev   <= 1'b1;
        end else begin
            r_state       <= w_state_next;
            r_count       <= w_count_next;
            r_err         <= w_err_next;
            r_timer       <= w_timer_next;
            r_disp_req    <= w_disp_req_next;
            r_disp_amt    <= w_disp_amt_next;
            r_card_eject  <= w_card_eject_next;
            r_card_retain <= w_card_retain_next;
            r_out         <= w_out_next;
            r_card_prev   <= i_card_insert;
        end
    end

    assign o_disp_req    = r_disp_req;
    assign o_disp_amt    = r_disp_amt;
    assign o_card_eject  = r_card_eject;
    assign o_card_retain = r_card_retain;
    assign o_out         = r_out;
    assign o_err         = r_err;
    assign o_state       = r_state;
    assign o_count       = r_count;

endmodule
